// File: rtl/dmem_pkg.sv
// Shared types and the byte-lane mask helper for the sized data memory.
// Lane masks are built MAX_LANES wide so one helper serves every XLEN up to 128.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
  typedef enum logic {ST_IDLE, ST_RESP} mem_state_e;

  localparam int MAX_LANES = 16;

  function automatic logic [MAX_LANES-1:0] lane_mask(input mem_size_e size, input logic [3:0] lane);
    logic [MAX_LANES-1:0] base;
    case (size)
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: in store mode replicates the low bytes across every lane group,
// in load mode extracts the addressed bytes and sign/zero extends them to XLEN.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit LOAD  = 1'b0,
  localparam int LANES = XLEN / 8,
  localparam int LW    = $clog2(LANES)
) (
  input  mem_size_e        size_i,
  input  logic             unsign_i,
  input  logic [LW-1:0]    lane_i,
  input  logic [XLEN-1:0]  data_i,
  output logic [XLEN-1:0]  data_o,
  output logic [LANES-1:0] mask_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] repl;
  logic            sign;
  int unsigned     nbits;

  assign mask_o = LANES'(lane_mask(size_i, 4'(lane_i)));

  // Aligned accesses make lane mod access-size equal the byte offset, so replication suffices.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_repl
    assign repl[gi*8 +: 8] = (size_i == SZ_B) ? data_i[7:0] :
                             (size_i == SZ_H) ? data_i[(gi % 2)*8 +: 8] :
                             (size_i == SZ_W) ? data_i[(gi % 4)*8 +: 8] :
                                                data_i[(gi % 8)*8 +: 8];
  end

  always_comb begin
    nbits   = 32'd8 << size_i;
    shifted = data_i >> {lane_i, 3'b000};
    if (nbits >= XLEN) begin
      low_mask = '1;
    end else begin
      low_mask = (XLEN'(1) << nbits) - XLEN'(1);
    end
    sign = |(shifted & low_mask & ~(low_mask >> 1));
    ext  = shifted & low_mask;
    if (!unsign_i && sign) begin
      ext = ext | ~low_mask;
    end
    data_o = LOAD ? ext : repl;
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized RV64 data memory: B/H/W/D loads and byte-lane stores behind a valid/ready
// request/response handshake, one-cycle registered read, misalign/range error reporting.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int LANES = XLEN / 8;
  localparam int LW    = $clog2(LANES);
  localparam int AW    = $clog2(DEPTH);
  localparam int WW    = ADDR_W - LW;

  mem_state_e      state_q, state_d;
  mem_size_e       req_sz;
  logic [LW-1:0]   req_lane;
  logic [WW-1:0]   req_word_full;
  logic [AW-1:0]   req_word;
  logic            misalign, out_of_range, too_wide, req_err, accept;

  logic [XLEN-1:0]  st_data;
  logic [LANES-1:0] st_mask;
  logic [XLEN-1:0]  ld_data;
  logic [LANES-1:0] ld_mask_unused;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word_q;
  mem_size_e       sz_q;
  logic [LW-1:0]   lane_q;
  logic            unsign_q, err_q, ld_ok_q;

  assign req_sz        = mem_size_e'(req_size);
  assign req_lane      = req_addr[LW-1:0];
  assign req_word_full = req_addr[ADDR_W-1:LW];
  assign req_word      = req_word_full[AW-1:0];

  always_comb begin
    case (req_sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_addr[0];
      SZ_W:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end

  // Full upper address is compared so out-of-range words never alias into the array.
  assign out_of_range = req_word_full >= WW'(DEPTH);
  assign too_wide     = (32'd8 << req_size) > XLEN;
  assign req_err      = misalign || out_of_range || too_wide;

  assign req_ready = !reset && ((state_q == ST_IDLE) || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sz_q     <= SZ_B;
      lane_q   <= '0;
      unsign_q <= 1'b0;
      err_q    <= 1'b0;
      ld_ok_q  <= 1'b0;
    end else if (accept) begin
      sz_q     <= req_sz;
      lane_q   <= req_lane;
      unsign_q <= req_unsign;
      err_q    <= req_err;
      ld_ok_q  <= !req_err && !req_write;
    end
  end

  dmem_lane_align #(.XLEN(XLEN), .LOAD(1'b0)) u_store_align (
    .size_i   (req_sz),
    .unsign_i (1'b0),
    .lane_i   (req_lane),
    .data_i   (req_wdata),
    .data_o   (st_data),
    .mask_o   (st_mask)
  );

  // Storage keeps no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (accept && !req_err) begin
      if (req_write) begin
        for (int i = 0; i < LANES; i++) begin
          if (st_mask[i]) mem[req_word][i*8 +: 8] <= st_data[i*8 +: 8];
        end
      end else begin
        rd_word_q <= mem[req_word];
      end
    end
  end

  dmem_lane_align #(.XLEN(XLEN), .LOAD(1'b1)) u_load_align (
    .size_i   (sz_q),
    .unsign_i (unsign_q),
    .lane_i   (lane_q),
    .data_i   (rd_word_q),
    .data_o   (ld_data),
    .mask_o   (ld_mask_unused)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = (rsp_valid && ld_ok_q) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: sized loads/stores, back-to-back ordering,
// error reporting, backpressure and asynchronous reset.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsign;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  dmem_sized #(.XLEN(64), .DEPTH(1024), .ADDR_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_unsign (req_unsign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one request with rsp_ready=1 and samples the response 1ns after the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output logic vld);
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsign = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    rd = rsp_rdata; er = rsp_err; vld = rsp_valid;
    $display("txn w=%0b sz=%0d u=%0b addr=%h wdata=%h -> vld=%0b err=%0b rdata=%h",
             w, sz, uns, addr, wd, vld, er, rd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sized_loads();
    logic [63:0] rd; logic er, vld;
    logic [1:0]  szs [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] adr [4] = '{64'h17, 64'h17, 64'h12, 64'h14};
    logic [63:0] exp [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_00FE,
                             64'h0000_0000_0000_7654, 64'hFFFF_FFFF_FEDC_BA98};
    issue(1'b1, 2'd3, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, rd, er, vld);
    n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL sd_0x0_err: got %b want 0", er); end
    issue(1'b1, 2'd3, 1'b0, 64'h10, 64'hFEDC_BA98_7654_3210, rd, er, vld);
    n_vec++; if (vld !== 1'b1) begin n_bad++; $display("FAIL sd_0x10_valid: got %b want 1", vld); end
    n_vec++; if (rd !== 64'h0) begin n_bad++; $display("FAIL sd_0x10_rdata: got %h want 0", rd); end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, szs[i], uns[i], adr[i], 64'h0, rd, er, vld);
      n_vec++; if (rd !== exp[i]) begin n_bad++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exp[i]); end
      n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL load%0d_err: got %b want 0", i, er); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsign = 1'b0;
    req_addr = 64'h11; req_wdata = 64'h0000_0000_0000_00AB; rsp_ready = 1'b1;
    @(posedge clk); #1;
    $display("txn SB @0x11 -> vld=%0b err=%0b rdata=%h", rsp_valid, rsp_err, rsp_rdata);
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL b2b_sb_err: got %b want 0", rsp_err); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd3; req_addr = 64'h10; req_wdata = 64'h0;
    @(posedge clk); #1;
    $display("txn LD @0x10 -> vld=%0b err=%0b rdata=%h", rsp_valid, rsp_err, rsp_rdata);
    n_vec++; if (rsp_rdata !== 64'hFEDC_BA98_7654_AB10) begin n_bad++; $display("FAIL b2b_ld_rdata: got %h want FEDCBA987654AB10", rsp_rdata); end
    n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ld_valid: got %b want 1", rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic er, vld;
    issue(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, rd, er, vld);
    n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL lw_0x12_err: got %b want 1", er); end
    n_vec++; if (rd !== 64'h0) begin n_bad++; $display("FAIL lw_0x12_rdata: got %h want 0", rd); end
    issue(1'b1, 2'd1, 1'b0, 64'h13, 64'h0000_0000_0000_FFFF, rd, er, vld);
    n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL sh_0x13_err: got %b want 1", er); end
    issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, vld);
    n_vec++; if (rd !== 64'hFEDC_BA98_7654_AB10) begin n_bad++; $display("FAIL misalign_unchanged: got %h want FEDCBA987654AB10", rd); end
  endtask

  task automatic test_range_backpressure();
    logic [63:0] rd; logic er, vld;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsign = 1'b0;
    req_addr = 64'h2000; req_wdata = 64'h1111_1111_1111_1111; rsp_ready = 1'b0;
    @(posedge clk); #1;
    $display("txn SD @0x2000 -> vld=%0b err=%0b rdata=%h", rsp_valid, rsp_err, rsp_rdata);
    n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL oor_valid: got %b want 1", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", rsp_err); end
    n_vec++; if (rsp_rdata !== 64'h0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", rsp_rdata); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_ready: got %b want 0", k, req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_valid: got %b want 1", k, rsp_valid); end
      n_vec++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL stall%0d_err: got %b want 1", k, rsp_err); end
    end
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_single_rsp: got %b want 0", rsp_valid); end
    issue(1'b1, 2'd3, 1'b0, 64'h8000_0000_0000_0000, 64'h2222_2222_2222_2222, rd, er, vld);
    n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL high_addr_err: got %b want 1", er); end
    issue(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, rd, er, vld);
    n_vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL no_wrap_word0: got %h want 0123456789ABCDEF", rd); end
  endtask

  task automatic test_async_reset();
    logic [63:0] rd; logic er, vld;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsign = 1'b0;
    req_addr = 64'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b want 1", rsp_valid); end
    #1 reset = 1'b1;
    #1;
    $display("txn async reset mid-cycle -> vld=%0b err=%0b rdata=%h", rsp_valid, rsp_err, rsp_rdata);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 64'h0) begin n_bad++; $display("FAIL async_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL async_ready: got %b want 0", req_ready); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_blocks_accept: got %b want 0", rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, vld);
    n_vec++; if (rd !== 64'hFEDC_BA98_7654_AB10) begin n_bad++; $display("FAIL post_reset_ld: got %h want FEDCBA987654AB10", rd); end
    n_vec++; if (vld !== 1'b1) begin n_bad++; $display("FAIL post_reset_valid: got %b want 1", vld); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsign = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; rsp_ready = 1'b1;
    test_reset();
    test_sized_loads();
    test_back_to_back();
    test_misaligned();
    test_range_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
